board_to_colors: RTL and testbench



---
 rtl/board_pkg.sv | 32 +++
 rtl/board_to_colors_if.sv | 25 ++
 rtl/cell_to_color.sv | 27 ++
 rtl/board_to_colors.sv | 40 ++++
 tb/tb_board_to_colors.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/board_pkg.sv
// Board geometry defaults, piece codes and the RGB332 palette
// shared by the board-to-colour path.
package board_pkg;

    localparam int BOARD_ROWS   = 12;
    localparam int BOARD_COLS   = 10;
    localparam int CELL_CODE_W  = 4;
    localparam int CELL_COLOR_W = 8;

    localparam logic [CELL_CODE_W-1:0] EMPTY        = 4'd0;
    localparam logic [CELL_CODE_W-1:0] T_PIECE      = 4'd1;
    localparam logic [CELL_CODE_W-1:0] SQUARE_PIECE = 4'd2;
    localparam logic [CELL_CODE_W-1:0] J_PIECE      = 4'd3;
    localparam logic [CELL_CODE_W-1:0] L_PIECE      = 4'd4;
    localparam logic [CELL_CODE_W-1:0] Z_PIECE      = 4'd5;
    localparam logic [CELL_CODE_W-1:0] S_PIECE      = 4'd6;
    localparam logic [CELL_CODE_W-1:0] LINE_PIECE   = 4'd7;
    localparam logic [CELL_CODE_W-1:0] CURSED_PIECE = 4'd8;
    localparam logic [CELL_CODE_W-1:0] FLASH_COLOR  = 4'd9;

    localparam logic [CELL_COLOR_W-1:0] EMPTY_RGB  = 8'h00;
    localparam logic [CELL_COLOR_W-1:0] T_RGB      = 8'hA2;
    localparam logic [CELL_COLOR_W-1:0] SQUARE_RGB = 8'hFC;
    localparam logic [CELL_COLOR_W-1:0] J_RGB      = 8'h03;
    localparam logic [CELL_COLOR_W-1:0] L_RGB      = 8'hF0;
    localparam logic [CELL_COLOR_W-1:0] Z_RGB      = 8'hE0;
    localparam logic [CELL_COLOR_W-1:0] S_RGB      = 8'h1C;
    localparam logic [CELL_COLOR_W-1:0] LINE_RGB   = 8'h1F;
    localparam logic [CELL_COLOR_W-1:0] CURSED_RGB = 8'h49;
    localparam logic [CELL_COLOR_W-1:0] FLASH_RGB  = 8'hFF;

endpackage

// File: rtl/board_to_colors_if.sv
// Board/colour bundle between the game controller, the colour
// mapper and the display driver.
interface board_to_colors_if
    import board_pkg::*;
#(
    parameter int ROWS    = BOARD_ROWS,
    parameter int COLS    = BOARD_COLS,
    parameter int CODE_W  = CELL_CODE_W,
    parameter int COLOR_W = CELL_COLOR_W
);

    logic [0:COLS*CODE_W-1]  board       [0:ROWS-1];
    logic [0:COLS*COLOR_W-1] colorValues [0:ROWS-1];

    modport master (
        output board,
        input  colorValues
    );

    modport slave (
        input  board,
        output colorValues
    );

endinterface

// File: rtl/cell_to_color.sv
// Combinational piece-code to RGB332 lookup for one board cell.
// Unused codes render black so OR-merged codes never show garbage.
module cell_to_color
    import board_pkg::*;
(
    input  logic [CELL_CODE_W-1:0]  code,
    output logic [CELL_COLOR_W-1:0] color
);

    always_comb begin
        color = EMPTY_RGB;
        case (code)
            EMPTY:        color = EMPTY_RGB;
            T_PIECE:      color = T_RGB;
            SQUARE_PIECE: color = SQUARE_RGB;
            J_PIECE:      color = J_RGB;
            L_PIECE:      color = L_RGB;
            Z_PIECE:      color = Z_RGB;
            S_PIECE:      color = S_RGB;
            LINE_PIECE:   color = LINE_RGB;
            CURSED_PIECE: color = CURSED_RGB;
            FLASH_COLOR:  color = FLASH_RGB;
            default:      color = EMPTY_RGB;
        endcase
    end

endmodule

// File: rtl/board_to_colors.sv
// Maps every board cell code to its display colour, registered
// with one clock of latency and a synchronous clear.
module board_to_colors
    import board_pkg::*;
#(
    parameter int ROWS    = BOARD_ROWS,
    parameter int COLS    = BOARD_COLS,
    parameter int CODE_W  = CELL_CODE_W,
    parameter int COLOR_W = CELL_COLOR_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [0:COLS*CODE_W-1]  board       [0:ROWS-1],
    output logic [0:COLS*COLOR_W-1] colorValues [0:ROWS-1]
);

    logic [COLOR_W-1:0] mapped [0:ROWS-1][0:COLS-1];

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            // Ascending slice: lowest bit index is the code MSB.
            cell_to_color u_cell (
                .code  (board[r][c*CODE_W +: CODE_W]),
                .color (mapped[r][c])
            );
        end
    end

    always_ff @(posedge clk) begin
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (reset)
                    colorValues[r][c*COLOR_W +: COLOR_W] <= '0;
                else
                    colorValues[r][c*COLOR_W +: COLOR_W] <= mapped[r][c];
            end
        end
    end

endmodule

// File: tb/tb_board_to_colors.sv
// Randomized self-checking bench for board_to_colors against a
// palette-table reference model.
module tb_board_to_colors;
    import board_pkg::*;

    localparam int R = BOARD_ROWS;
    localparam int C = BOARD_COLS;

    logic clk = 1'b0;
    logic reset = 1'b1;

    board_to_colors_if bus ();

    board_to_colors dut (
        .clk         (clk),
        .reset       (reset),
        .board       (bus.board),
        .colorValues (bus.colorValues)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cb [R][C];
    logic [7:0] pal [16];

    function automatic logic [7:0] model(input int code);
        return pal[code & 15];
    endfunction

    function automatic logic [7:0] actual(input int r, input int c);
        return bus.colorValues[r][c*8 +: 8];
    endfunction

    task automatic apply();
        logic [3:0] v;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) begin
                v = cb[r][c][3:0];
                bus.board[r][c*4 +: 4] = v;
            end
    endtask

    task automatic fill(input int code);
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                cb[r][c] = code;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        fill(2);
        apply();
        tick();
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) begin
                tests++;
                if (actual(r, c) !== 8'h00) begin
                    fails++;
                    $display("FAIL reset_hold r%0d c%0d got %h exp 00",
                             r, c, actual(r, c));
                end
            end
        reset = 1'b0;
        tick();
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) begin
                tests++;
                if (actual(r, c) !== 8'hFC) begin
                    fails++;
                    $display("FAIL reset_release r%0d c%0d got %h exp FC",
                             r, c, actual(r, c));
                end
            end
    endtask

    task automatic test_palette();
        fill(0);
        for (int c = 0; c < C; c++) cb[0][c] = c;
        apply();
        tick();
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) begin
                tests++;
                if (actual(r, c) !== model(cb[r][c])) begin
                    fails++;
                    $display("FAIL palette r%0d c%0d got %h exp %h",
                             r, c, actual(r, c), model(cb[r][c]));
                end
            end
    endtask

    task automatic test_bit_order();
        logic [7:0] e;
        fill(0);
        apply();
        bus.board[11][36:39] = 4'b0111;
        bus.board[0][0:3] = 4'b0001;
        tick();
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) begin
                e = 8'h00;
                if (r == 11 && c == 9) e = 8'h1F;
                if (r == 0 && c == 0) e = 8'hA2;
                tests++;
                if (actual(r, c) !== e) begin
                    fails++;
                    $display("FAIL bit_order r%0d c%0d got %h exp %h",
                             r, c, actual(r, c), e);
                end
            end
        tests++;
        if (bus.colorValues[11][72:79] !== 8'h1F) begin
            fails++;
            $display("FAIL bit_order_raw got %h exp 1F",
                     bus.colorValues[11][72:79]);
        end
    endtask

    task automatic test_invalid();
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                cb[r][c] = 10 + ((r * C + c) % 6);
        apply();
        tick();
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) begin
                tests++;
                if (actual(r, c) !== 8'h00) begin
                    fails++;
                    $display("FAIL invalid r%0d c%0d got %h exp 00",
                             r, c, actual(r, c));
                end
            end
    endtask

    task automatic test_latency();
        int cur;
        int prev;
        fill(1);
        apply();
        tick();
        prev = 1;
        for (int k = 0; k < 8; k++) begin
            cur = (k % 2 == 0) ? 9 : 1;
            fill(cur);
            apply();
            #1;
            tests++;
            if (actual(k % R, k % C) !== model(prev)) begin
                fails++;
                $display("FAIL latency_hold k%0d got %h exp %h",
                         k, actual(k % R, k % C), model(prev));
            end
            tick();
            for (int r = 0; r < R; r++)
                for (int c = 0; c < C; c++) begin
                    tests++;
                    if (actual(r, c) !== model(cur)) begin
                        fails++;
                        $display("FAIL latency k%0d r%0d c%0d got %h exp %h",
                                 k, r, c, actual(r, c), model(cur));
                    end
                end
            prev = cur;
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 20; k++) begin
            for (int r = 0; r < R; r++)
                for (int c = 0; c < C; c++)
                    cb[r][c] = int'($urandom_range(15, 0));
            apply();
            tick();
            for (int r = 0; r < R; r++)
                for (int c = 0; c < C; c++) begin
                    tests++;
                    if (actual(r, c) !== model(cb[r][c])) begin
                        fails++;
                        $display("FAIL random k%0d r%0d c%0d got %h exp %h",
                                 k, r, c, actual(r, c), model(cb[r][c]));
                    end
                end
        end
    endtask

    task automatic test_mid_reset();
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                cb[r][c] = int'($urandom_range(9, 1));
        apply();
        tick();
        reset = 1'b1;
        tick();
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) begin
                tests++;
                if (actual(r, c) !== 8'h00) begin
                    fails++;
                    $display("FAIL mid_reset r%0d c%0d got %h exp 00",
                             r, c, actual(r, c));
                end
            end
        reset = 1'b0;
        tick();
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) begin
                tests++;
                if (actual(r, c) !== model(cb[r][c])) begin
                    fails++;
                    $display("FAIL mid_resume r%0d c%0d got %h exp %h",
                             r, c, actual(r, c), model(cb[r][c]));
                end
            end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) pal[i] = 8'h00;
        pal[1] = 8'hA2;
        pal[2] = 8'hFC;
        pal[3] = 8'h03;
        pal[4] = 8'hF0;
        pal[5] = 8'hE0;
        pal[6] = 8'h1C;
        pal[7] = 8'h1F;
        pal[8] = 8'h49;
        pal[9] = 8'hFF;
        fill(0);
        apply();
        test_reset();
        test_palette();
        test_bit_order();
        test_invalid();
        test_latency();
        test_random();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
